// File: rtl/drum_mul_arbiter_if.sv
// Bundle of request, multiplier and result signals around the shared DRUM multiplier.
// master = requesters/multiplier/downstream side, slave = the arbiter.
interface drum_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int IDW     = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]         mul_a;
    logic [WIDTH-1:0]         mul_b;
    logic [2*WIDTH-1:0]       mul_r;
    logic                     out_valid;
    logic                     out_ready;
    logic [2*WIDTH-1:0]       out_r;
    logic [IDW-1:0]           out_id;

    modport master (
        output req_valid, req_a, req_b, mul_r, out_ready,
        input  req_ready, mul_a, mul_b, out_valid, out_r, out_id
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_r, out_ready,
        output req_ready, mul_a, mul_b, out_valid, out_r, out_id
    );
endinterface

// File: rtl/drum_mul_arbiter.sv
// Round-robin arbiter sharing one external combinational multiplier between NUM_REQ
// requesters, with an operand stage (S1) and a result stage (S2), results tagged by ID.
module drum_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int IDW     = 2
) (
    input  logic              clk,
    input  logic              rst,
    drum_mul_arbiter_if.slave bus
);
    logic [WIDTH-1:0]   req_a_arr [NUM_REQ];
    logic [WIDTH-1:0]   req_b_arr [NUM_REQ];
    logic [NUM_REQ-1:0] ready_vec;

    logic               s1_valid_reg;
    logic [WIDTH-1:0]   s1_a_reg;
    logic [WIDTH-1:0]   s1_b_reg;
    logic [IDW-1:0]     s1_id_reg;
    logic               s2_valid_reg;
    logic [2*WIDTH-1:0] s2_r_reg;
    logic [IDW-1:0]     s2_id_reg;
    logic [IDW-1:0]     ptr_reg;
    logic [IDW-1:0]     ptr_next;

    logic               s2_free;
    logic               s1_adv;
    logic               s1_free;
    logic               grant_valid;
    logic [IDW-1:0]     grant_id;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_a_arr[gi] = bus.req_a[gi*WIDTH +: WIDTH];
            assign req_b_arr[gi] = bus.req_b[gi*WIDTH +: WIDTH];
            assign ready_vec[gi] = grant_valid && (grant_id == IDW'(gi));
        end
    endgenerate

    assign s2_free = !s2_valid_reg || bus.out_ready;
    assign s1_adv  = s1_valid_reg && s2_free;
    assign s1_free = !s1_valid_reg || s1_adv;

    // Scan from the highest offset down so the last hit is the nearest valid at/after ptr.
    always_comb begin : p_arb
        logic [IDW:0] idx;
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = '0;
        if (s1_free) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = {1'b0, ptr_reg} + (IDW+1)'(k);
                if (idx >= (IDW+1)'(NUM_REQ)) begin
                    idx = idx - (IDW+1)'(NUM_REQ);
                end
                if (bus.req_valid[idx[IDW-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_id    = idx[IDW-1:0];
                end
            end
        end
    end

    assign ptr_next = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_id_reg    <= '0;
            s2_valid_reg <= 1'b0;
            s2_r_reg     <= '0;
            s2_id_reg    <= '0;
            ptr_reg      <= '0;
        end else begin
            if (s1_adv) begin
                s2_r_reg     <= bus.mul_r;
                s2_id_reg    <= s1_id_reg;
                s2_valid_reg <= 1'b1;
            end else if (bus.out_ready) begin
                s2_valid_reg <= 1'b0;
            end
            s1_valid_reg <= grant_valid || (s1_valid_reg && !s1_adv);
            if (grant_valid) begin
                s1_a_reg  <= req_a_arr[grant_id];
                s1_b_reg  <= req_b_arr[grant_id];
                s1_id_reg <= grant_id;
                ptr_reg   <= ptr_next;
            end
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.mul_a     = s1_a_reg;
    assign bus.mul_b     = s1_b_reg;
    assign bus.out_valid = s2_valid_reg;
    assign bus.out_r     = s2_r_reg;
    assign bus.out_id    = s2_id_reg;
endmodule

// File: tb/tb_drum_mul_arbiter.sv
// Bench for drum_mul_arbiter: directed scenarios plus a short random soak, with an
// in-order scoreboard fed at each accepted request and drained by an output monitor.
module tb_drum_mul_arbiter;
    localparam int NR = 4;
    localparam int W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    drum_mul_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .IDW(2)) bus ();

    drum_mul_arbiter #(.NUM_REQ(NR), .WIDTH(W), .IDW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // DRUM multiplier model with k=8 kept bits and the unbiasing LSB forced to 1.
    function automatic logic [31:0] drum_mul(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] ta, tb2;
        int sa, sb;
        ta = a; tb2 = b; sa = 0; sb = 0;
        for (int p = 15; p >= 8; p--) begin
            if (a[p] && sa == 0) sa = p - 7;
            if (b[p] && sb == 0) sb = p - 7;
        end
        if (sa > 0) ta = (a >> sa) | 16'd1;
        if (sb > 0) tb2 = (b >> sb) | 16'd1;
        return (32'(ta) * 32'(tb2)) << (sa + sb);
    endfunction

    assign bus.mul_r = drum_mul(bus.mul_a, bus.mul_b);

    int vectors = 0;
    int miscompares = 0;

    logic [3:0]  rv;
    logic [15:0] ra [NR];
    logic [15:0] rb [NR];
    logic [31:0] exp_r [NR];
    logic [33:0] exp_q [$];
    logic [3:0]  last_acc;
    int          wait_cnt [NR];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        bus.req_valid = rv;
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i*W +: W] = ra[i];
            bus.req_b[i*W +: W] = rb[i];
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] e);
        ra[i] = a; rb[i] = b; exp_r[i] = e;
    endtask

    // Scoreboard feed: every accepted request pushes its expected tagged product.
    always @(negedge clk) begin
        if (rst) begin
            last_acc <= '0;
            for (int i = 0; i < NR; i++) wait_cnt[i] <= 0;
        end else begin
            last_acc <= bus.req_valid & bus.req_ready;
            for (int i = 0; i < NR; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    exp_q.push_back({2'(i), exp_r[i]});
                    check($sformatf("wait_grants_id%0d", i), 64'(wait_cnt[i] < NR), 64'd1);
                    wait_cnt[i] <= 0;
                end else if (bus.req_valid[i] && (bus.req_ready != 0)) begin
                    wait_cnt[i] <= wait_cnt[i] + 1;
                end else if (!bus.req_valid[i]) begin
                    wait_cnt[i] <= 0;
                end
            end
        end
    end

    // Output monitor: pops one expectation per delivered result.
    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: got id %0d r %0h expected nothing",
                         bus.out_id, bus.out_r);
            end else begin
                e = exp_q.pop_front();
                $display("result id=%0d r=%08h", bus.out_id, bus.out_r);
                check("result_id_r", 64'({bus.out_id, bus.out_r}), 64'(e));
            end
        end
    end

    initial begin
        int acc;
        logic [31:0] held_r;
        logic [1:0]  held_id;
        logic [15:0] bp_a [3];
        logic [15:0] bp_b [3];
        logic [31:0] bp_e [3];
        bp_a = '{16'd2, 16'd4, 16'd6};
        bp_b = '{16'd3, 16'd5, 16'd7};
        bp_e = '{32'd6, 32'd20, 32'd42};

        rv = '0;
        for (int i = 0; i < NR; i++) set_req(i, '0, '0, '0);
        drive();
        bus.out_ready = 1'b1;
        repeat (2) tick();
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_out_r", 64'(bus.out_r), 64'd0);
        check("reset_mul_a", 64'(bus.mul_a), 64'd0);
        rst = 1'b0;

        // Single request from requester 2
        set_req(2, 16'h000F, 16'h000F, 32'h000000E1);
        rv = 4'b0100; drive();
        #1 check("single_ready", 64'(bus.req_ready), 64'h4);
        tick();
        rv = '0; drive();
        check("single_mul_a", 64'(bus.mul_a), 64'h000F);
        check("single_not_yet_valid", 64'(bus.out_valid), 64'd0);
        tick();
        check("single_out", 64'({bus.out_valid, bus.out_id, bus.out_r}), {1'b1, 2'd2, 32'hE1});
        repeat (3) tick();

        // Four-way round robin, back to back
        rst = 1'b1; #2 rst = 1'b0;
        set_req(0, 16'd3, 16'd5, 32'h0F);
        set_req(1, 16'd7, 16'd9, 32'h3F);
        set_req(2, 16'd10, 16'd10, 32'h64);
        set_req(3, 16'd0, 16'd0, 32'h00);
        rv = 4'b1111; drive();
        for (int k = 0; k < 8; k++) begin
            #1 check($sformatf("rr_ready_%0d", k), 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
            if (k >= 2) check($sformatf("rr_b2b_valid_%0d", k), 64'(bus.out_valid), 64'd1);
            tick();
        end
        rv = '0; drive();
        repeat (3) tick();

        // Backpressure with requester 1 held valid
        bus.out_ready = 1'b0;
        acc = 0;
        set_req(1, bp_a[0], bp_b[0], bp_e[0]);
        rv = 4'b0010; drive();
        for (int k = 0; k < 5; k++) begin
            #1 if (bus.req_ready[1]) acc++;
            tick();
            set_req(1, bp_a[acc], bp_b[acc], bp_e[acc]); drive();
        end
        held_r = bus.out_r; held_id = bus.out_id;
        check("bp_accept_count", 64'(acc), 64'd2);
        #1 check("bp_ready_low", 64'(bus.req_ready), 64'd0);
        check("bp_hold_out", 64'({bus.out_valid, bus.out_id, bus.out_r}), {1'b1, 2'd1, 32'd6});
        tick();
        check("bp_stable", 64'({bus.out_id, bus.out_r}), 64'({held_id, held_r}));
        rv = '0; drive();
        bus.out_ready = 1'b1;
        repeat (4) tick();
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Pointer wrap: ptr is 2 here
        set_req(3, 16'd4, 16'd4, 32'd16);
        set_req(0, 16'd5, 16'd6, 32'd30);
        rv = 4'b1000; drive();
        #1 check("wrap_only3", 64'(bus.req_ready), 64'h8);
        tick();
        rv = 4'b1001; drive();
        #1 check("wrap_to_0", 64'(bus.req_ready), 64'h1);
        tick();
        rv = 4'b1000; drive();
        #1 check("wrap_lone3", 64'(bus.req_ready), 64'h8);
        tick();
        rv = '0; drive();
        repeat (3) tick();

        // Reset with both stages full
        bus.out_ready = 1'b0;
        set_req(0, 16'd7, 16'd8, 32'd56);
        rv = 4'b0001; drive();
        repeat (2) tick();
        rv = '0; drive();
        check("mid_full", 64'(bus.out_valid), 64'd1);
        #2 rst = 1'b1;
        #1 check("mid_rst_out", 64'({bus.out_valid, bus.out_id, bus.out_r}), 64'd0);
        check("mid_rst_mul", 64'({bus.mul_a, bus.mul_b}), 64'd0);
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        rv = 4'b1111; drive();
        #1 check("mid_tie_req0", 64'(bus.req_ready), 64'h1);
        tick();
        rv = '0; drive();
        repeat (4) tick();

        // Random soak: requests held until accepted, random downstream stalls
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (last_acc[i]) rv[i] = 1'b0;
                if (!rv[i] && $urandom_range(0, 3) != 0) begin
                    ra[i] = 16'($urandom);
                    rb[i] = 16'($urandom);
                    exp_r[i] = drum_mul(ra[i], rb[i]);
                    rv[i] = 1'b1;
                end
            end
            drive();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        // Drop only requests that were just accepted is not enough; stop all and drain.
        rv = '0; drive();
        bus.out_ready = 1'b1;
        repeat (6) tick();
        check("soak_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
